video_mode_ctrl: RTL and testbench
==================================

# video_mode_ctrl

Runtime video-mode sequencer for the HDMI output path. It owns the horizontal and vertical timing parameters fed to the pixel timing generator, and accepts mode-change requests through a ready/request handshake. It applies a new mode only at a frame boundary, using a blank → driver-reset → reload → blank sequence, so the sink never sees a torn or malformed frame. It sits between the system control logic and the timing generator, and drives the generator's reset and the output blanking gate.

## Interface
Parameters:
- DEFAULT_MODE, 2'd0, mode loaded at reset.
- BLANK_FRAMES, 2, black frames emitted on the new timing before unblanking (1..15).
- RST_CYCLES, 16, pixel_clk cycles the timing generator is held in reset (2..255).
- VS_TIMEOUT, 4_000_000, max cycles to wait for a frame edge before proceeding anyway (23-bit counter).

Ports:
- pixel_clk, in, 1, pixel clock; all logic in this domain.
- sys_rst_n, in, 1, asynchronous, active-low reset.
- mode_req, in, 1, request strobe; sampled only while mode_ready=1.
- mode_sel, in, 2, requested mode: 0=1280x720, 1=1920x1080, 2=640x480, 3=800x600.
- mode_ready, out, 1, =1 only in IDLE.
- mode_done, out, 1, one-cycle pulse when the new mode is live and unblanked.
- mode_cur, out, 2, mode currently driven on the timing outputs.
- vs_timeout, out, 1, sticky; set when any frame-edge wait expires; cleared on the next accepted request.
- video_vs, in, 1, active-low vsync from the timing generator.
- drv_rst_n, out, 1, active-low reset to the timing generator.
- blank, out, 1, forces output RGB to 0 when 1.
- h_sync, h_back, h_disp, h_front, h_total, out, 12 each, horizontal timing.
- v_sync, v_back, v_disp, v_front, v_total, out, 12 each, vertical timing.

## Operation
- Mode table (sync/back/disp/front/total):
  - Mode 0: H 40/220/1280/110/1650; V 5/20/720/5/750.
  - Mode 1: H 44/148/1920/88/2200; V 5/36/1080/4/1125.
  - Mode 2: H 96/48/640/16/800; V 2/33/480/10/525.
  - Mode 3: H 128/88/800/40/1056; V 4/23/600/1/628.
- Frame edge: falling edge of video_vs, i.e. vs_d=1 and video_vs=0. vs_d resets to 1.
- States:
  - IDLE: on mode_req, latch mode_sel into tgt. If tgt==mode_cur go to DONE; else go to WAIT_VS.
  - WAIT_VS: on frame edge (or timeout), set blank=1 and go to BLANK_OLD.
  - BLANK_OLD: on the next frame edge (or timeout), go to HOLD_RST. On entry, load the timing outputs from tgt, set mode_cur=tgt, drv_rst_n=0, and load the cycle counter with RST_CYCLES-1.
  - HOLD_RST: count down. At 0, set drv_rst_n=1 and go to BLANK_NEW with the frame counter =0.
  - BLANK_NEW: increment the counter on each frame edge. When it reaches BLANK_FRAMES (or on timeout), go to DONE.
  - DONE: blank=0, mode_done=1 for exactly this cycle, then IDLE.
- Timeout: the cycle counter restarts at every state entry and every frame edge. Reaching VS_TIMEOUT-1 in WAIT_VS, BLANK_OLD or BLANK_NEW counts as an edge and sets vs_timeout.
- A frame edge and a timeout in the same cycle count as one edge.
- mode_req while mode_ready=0 is ignored. There is no queueing.
- The timing outputs change only on HOLD_RST entry, and are otherwise stable.

## Timing
- Reset values:
  - State IDLE, so mode_ready=1.
  - mode_done=0, blank=0, drv_rst_n=0, vs_timeout=0.
  - mode_cur=DEFAULT_MODE; timing outputs = DEFAULT_MODE table.
- drv_rst_n rises on the first clock edge after sys_rst_n deasserts.
- All outputs are registered, except mode_ready, which is decoded from state.
- Request sampled at edge N: mode_ready=0 from N+1.
  - Same-mode request: mode_done pulses at N+1, mode_ready=1 at N+2, blank never asserts.
- blank rises one cycle after the first frame edge following acceptance.
- Timing outputs and drv_rst_n=0 change in the same cycle. drv_rst_n stays low for exactly RST_CYCLES cycles.
- During the hold, video_vs is low, so vs_d=0 and no spurious edge is seen at release.
- blank falls in the same cycle mode_done is high.
- Reset mid-sequence: all state returns immediately to reset values. The timing outputs revert to DEFAULT_MODE.

## Test plan
- Reset with DEFAULT_MODE=0 → h_total=1650, v_total=750, mode_ready=1, drv_rst_n=0 during reset and 1 one cycle after release.
- Mode 0→1 with a behavioral timing generator → blank asserts one cycle after the next vs fall. After one more frame, drv_rst_n is low for 16 cycles and h_total=2200 / v_disp=1080. After 2 new frames, a single mode_done pulse with blank=0.
- Request mode 0 while mode_cur=0 → mode_done at N+1, blank stays 0, drv_rst_n stays 1.
- Second mode_req during BLANK_OLD → ignored; final mode_cur equals the first request.
- video_vs held high with VS_TIMEOUT=1000 → sequence completes via timeouts, vs_timeout=1 and stays 1 until the next accepted request.
- Assert sys_rst_n low during HOLD_RST → immediately mode_cur=DEFAULT_MODE, blank=0, drv_rst_n=0, state IDLE.

Source files
------------

// File: rtl/video_mode_ctrl.sv
// Video-mode sequencer: owns the timing-generator parameters and swaps them at a
// frame boundary through blank -> generator reset -> reload -> blank.
module video_mode_ctrl #(
  parameter logic [1:0]  DEFAULT_MODE = 2'd0,
  parameter int unsigned BLANK_FRAMES = 2,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned VS_TIMEOUT   = 4_000_000
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        mode_req,
  input  logic [1:0]  mode_sel,
  output logic        mode_ready,
  output logic        mode_done,
  output logic [1:0]  mode_cur,
  output logic        vs_timeout,
  input  logic        video_vs,
  output logic        drv_rst_n,
  output logic        blank,
  output logic [11:0] h_sync,
  output logic [11:0] h_back,
  output logic [11:0] h_disp,
  output logic [11:0] h_front,
  output logic [11:0] h_total,
  output logic [11:0] v_sync,
  output logic [11:0] v_back,
  output logic [11:0] v_disp,
  output logic [11:0] v_front,
  output logic [11:0] v_total,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_VS   = 3'd1,
    BLANK_OLD = 3'd2,
    HOLD_RST  = 3'd3,
    BLANK_NEW = 3'd4,
    DONE      = 3'd5
  } state_t;

  typedef struct packed {
    logic [11:0] h_sync, h_back, h_disp, h_front, h_total;
    logic [11:0] v_sync, v_back, v_disp, v_front, v_total;
  } timing_t;

  localparam logic [22:0] TMO_LAST   = 23'(VS_TIMEOUT - 1);
  localparam logic [22:0] RST_LOAD   = 23'(RST_CYCLES - 1);
  localparam logic [3:0]  BLANK_LAST = 4'(BLANK_FRAMES - 1);

  function automatic timing_t mode_timing(input logic [1:0] m);
    timing_t t;
    case (m)
      2'd1:    t = {12'd44, 12'd148, 12'd1920, 12'd88, 12'd2200,
                    12'd5,  12'd36,  12'd1080, 12'd4,  12'd1125};
      2'd2:    t = {12'd96, 12'd48,  12'd640,  12'd16, 12'd800,
                    12'd2,  12'd33,  12'd480,  12'd10, 12'd525};
      2'd3:    t = {12'd128, 12'd88, 12'd800,  12'd40, 12'd1056,
                    12'd4,   12'd23, 12'd600,  12'd1,  12'd628};
      default: t = {12'd40, 12'd220, 12'd1280, 12'd110, 12'd1650,
                    12'd5,  12'd20,  12'd720,  12'd5,   12'd750};
    endcase
    return t;
  endfunction

  state_t      state, state_nxt;
  timing_t     tim;
  logic        vs_d;
  logic [22:0] cyc_cnt;
  logic [3:0]  frm_cnt;
  logic [1:0]  tgt;
  logic        wait_state, vs_edge, tmo, frame_evt, accept;

  // Handshake: a request is taken only on a clock edge where mode_req=1 and
  // mode_ready=1; requests while busy are dropped, never queued.
  assign mode_ready = (state == IDLE);
  assign accept     = mode_ready && mode_req;
  assign fsm_state  = state;

  assign wait_state = (state == WAIT_VS) || (state == BLANK_OLD) || (state == BLANK_NEW);
  assign vs_edge    = vs_d && !video_vs;
  assign tmo        = wait_state && (cyc_cnt == TMO_LAST);
  assign frame_evt  = vs_edge || tmo;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = (mode_sel == mode_cur) ? DONE : WAIT_VS;
      WAIT_VS:   if (frame_evt) state_nxt = BLANK_OLD;
      BLANK_OLD: if (frame_evt) state_nxt = HOLD_RST;
      HOLD_RST:  if (cyc_cnt == '0) state_nxt = BLANK_NEW;
      BLANK_NEW: if (tmo || (vs_edge && frm_cnt == BLANK_LAST)) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign {h_sync, h_back, h_disp, h_front, h_total,
          v_sync, v_back, v_disp, v_front, v_total} = tim;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_d       <= 1'b1;
      cyc_cnt    <= '0;
      frm_cnt    <= '0;
      tgt        <= DEFAULT_MODE;
      mode_cur   <= DEFAULT_MODE;
      tim        <= mode_timing(DEFAULT_MODE);
      mode_done  <= 1'b0;
      blank      <= 1'b0;
      drv_rst_n  <= 1'b0;
      vs_timeout <= 1'b0;
    end else begin
      vs_d      <= video_vs;
      mode_done <= (state_nxt == DONE);
      blank     <= (state_nxt == BLANK_OLD) || (state_nxt == HOLD_RST) ||
                   (state_nxt == BLANK_NEW);
      drv_rst_n <= (state_nxt != HOLD_RST);

      // One counter serves both the reset hold (down) and the frame-edge watchdog (up).
      if (state_nxt != state)
        cyc_cnt <= (state_nxt == HOLD_RST) ? RST_LOAD : '0;
      else if (state == HOLD_RST)
        cyc_cnt <= cyc_cnt - 23'd1;
      else if (wait_state)
        cyc_cnt <= frame_evt ? '0 : cyc_cnt + 23'd1;
      else
        cyc_cnt <= '0;

      if (state_nxt == BLANK_NEW && state != BLANK_NEW)
        frm_cnt <= '0;
      else if (state == BLANK_NEW && vs_edge)
        frm_cnt <= frm_cnt + 4'd1;

      if (accept) tgt <= mode_sel;

      if (accept)   vs_timeout <= 1'b0;
      else if (tmo) vs_timeout <= 1'b1;

      if (state == BLANK_OLD && state_nxt == HOLD_RST) begin
        mode_cur <= tgt;
        tim      <= mode_timing(tgt);
      end
    end
  end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Bench for video_mode_ctrl: a shortened-frame timing generator model, request
// driver, done-pulse scoreboard and reset-hold / timing-stability monitors.
module tb_video_mode_ctrl;

  localparam int RST_CYCLES   = 16;
  localparam int BLANK_FRAMES = 2;
  localparam int VS_TIMEOUT   = 1000;
  localparam int FRAME        = 200;
  localparam int VS_LEN       = 8;
  localparam int W            = 123;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        mode_req  = 1'b0;
  logic [1:0]  mode_sel  = 2'd0;
  logic        mode_ready, mode_done, vs_timeout, drv_rst_n, blank, video_vs;
  logic [1:0]  mode_cur;
  logic [11:0] h_sync, h_back, h_disp, h_front, h_total;
  logic [11:0] v_sync, v_back, v_disp, v_front, v_total;
  logic [2:0]  fsm_state;
  logic [119:0] act_tim;

  // Reference mode table: sync/back/disp/front; totals are derived as the sum.
  int h_tab [4][4] = '{'{40, 220, 1280, 110}, '{44, 148, 1920, 88},
                       '{96, 48, 640, 16},    '{128, 88, 800, 40}};
  int v_tab [4][4] = '{'{5, 20, 720, 5}, '{5, 36, 1080, 4},
                       '{2, 33, 480, 10}, '{4, 23, 600, 1}};

  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [1:0]   model_cur = 2'd0;
  logic [1:0]   last_tgt  = 2'd0;
  logic         vs_at_accept = 1'b1;
  logic         vs_hold_high = 1'b0;
  int           gcnt = 0;

  video_mode_ctrl #(
    .DEFAULT_MODE(2'd0),
    .BLANK_FRAMES(BLANK_FRAMES),
    .RST_CYCLES(RST_CYCLES),
    .VS_TIMEOUT(VS_TIMEOUT)
  ) dut (
    .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n),
    .mode_req(mode_req), .mode_sel(mode_sel),
    .mode_ready(mode_ready), .mode_done(mode_done), .mode_cur(mode_cur),
    .vs_timeout(vs_timeout), .video_vs(video_vs),
    .drv_rst_n(drv_rst_n), .blank(blank),
    .h_sync(h_sync), .h_back(h_back), .h_disp(h_disp), .h_front(h_front), .h_total(h_total),
    .v_sync(v_sync), .v_back(v_back), .v_disp(v_disp), .v_front(v_front), .v_total(v_total),
    .fsm_state(fsm_state)
  );

  assign act_tim = {h_sync, h_back, h_disp, h_front, h_total,
                    v_sync, v_back, v_disp, v_front, v_total};

  // Clock / reset
  always #5 pixel_clk = ~pixel_clk;

  // Timing generator model: short fixed frame, vsync low at frame start and while held in reset.
  always @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)      gcnt <= 0;
    else if (!drv_rst_n) gcnt <= 0;
    else                 gcnt <= (gcnt == FRAME - 1) ? 0 : gcnt + 1;
  end
  assign video_vs = vs_hold_high | (drv_rst_n & (gcnt >= VS_LEN));

  function automatic logic [119:0] tim_pkt(input logic [1:0] m);
    int hs, hb, hd, hf, vs, vb, vd, vf;
    hs = h_tab[m][0]; hb = h_tab[m][1]; hd = h_tab[m][2]; hf = h_tab[m][3];
    vs = v_tab[m][0]; vb = v_tab[m][1]; vd = v_tab[m][2]; vf = v_tab[m][3];
    return {12'(hs), 12'(hb), 12'(hd), 12'(hf), 12'(hs + hb + hd + hf),
            12'(vs), 12'(vb), 12'(vd), 12'(vf), 12'(vs + vb + vd + vf)};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge pixel_clk);
    while (!mode_ready && n < 5000) begin
      @(negedge pixel_clk);
      n++;
    end
    check("wait_ready", W'(mode_ready), W'(1));
  endtask

  task automatic issue_req(input logic [1:0] m);
    wait_ready();
    vs_at_accept = video_vs;
    mode_sel = m;
    mode_req = 1'b1;
    @(posedge pixel_clk);
    exp_q.push_back({(vs_hold_high && (m != model_cur)), m, tim_pkt(m)});
    model_cur = m;
    last_tgt  = m;
    #1 mode_req = 1'b0;
  endtask

  task automatic issue_ignored(input logic [1:0] m);
    mode_sel = m;
    mode_req = 1'b1;
    @(posedge pixel_clk);
    #1 mode_req = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !mode_ready) && n < 8000) begin
      @(negedge pixel_clk);
      n++;
    end
    check("wait_done", W'(exp_q.size()), W'(0));
  endtask

  task automatic check_blank_rise();
    logic prev_vs;
    logic found;
    int   n;
    prev_vs = vs_at_accept;
    found   = 1'b0;
    n       = 0;
    while (!found && n < 1000) begin
      @(negedge pixel_clk);
      n++;
      if (prev_vs && !video_vs) begin
        found = 1'b1;
        check("blank_at_edge", W'(blank), W'(0));
        @(negedge pixel_clk);
        check("blank_rise", W'(blank), W'(1));
      end else begin
        prev_vs = video_vs;
      end
    end
    check("vs_edge_seen", W'(found), W'(1));
  endtask

  task automatic wait_level(input string name, input bit want_blank, input logic level);
    int n;
    n = 0;
    @(negedge pixel_clk);
    while (((want_blank ? blank : drv_rst_n) !== level) && n < 3000) begin
      @(negedge pixel_clk);
      n++;
    end
    check(name, W'(want_blank ? blank : drv_rst_n), W'(level));
  endtask

  // Scoreboard monitor: every mode_done pulse retires one expected response.
  initial begin
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge pixel_clk);
      if (sys_rst_n && mode_done) begin
        check("done_single", W'(prev_done), W'(0));
        check("done_blank", W'(blank), W'(0));
        check("done_drv_rst", W'(drv_rst_n), W'(1));
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_unexpected: mode_done pulsed with mode_cur=%0d, expected no pulse", mode_cur);
        end else begin
          check("done_pkt", {vs_timeout, mode_cur, act_tim}, exp_q.pop_front());
        end
      end
      prev_done = mode_done;
    end
  end

  // Generator reset hold length and timing reload at its start.
  initial begin
    logic prev_drv;
    logic in_pulse;
    int   low_len;
    prev_drv = 1'b0;
    in_pulse = 1'b0;
    low_len  = 0;
    forever begin
      @(negedge pixel_clk);
      if (!sys_rst_n) begin
        in_pulse = 1'b0;
        low_len  = 0;
      end else begin
        if (prev_drv && !drv_rst_n) begin
          in_pulse = 1'b1;
          low_len  = 0;
          check("reload_timing", W'({mode_cur, act_tim}), W'({last_tgt, tim_pkt(last_tgt)}));
        end
        if (in_pulse && !drv_rst_n) low_len++;
        if (in_pulse && drv_rst_n) begin
          in_pulse = 1'b0;
          check("rst_hold_len", W'(low_len), W'(RST_CYCLES));
        end
      end
      prev_drv = drv_rst_n;
    end
  end

  // Timing outputs may only change in the cycle drv_rst_n falls.
  initial begin
    logic [119:0] prev_tim;
    logic         prev_drv;
    prev_tim = act_tim;
    prev_drv = 1'b0;
    forever begin
      @(negedge pixel_clk);
      if (sys_rst_n && (act_tim !== prev_tim))
        check("timing_change_at_reload", W'(prev_drv && !drv_rst_n), W'(1));
      prev_tim = act_tim;
      prev_drv = drv_rst_n;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [1:0] m;
    repeat (3) @(negedge pixel_clk);
    check("rst_h_total", W'(h_total), W'(1650));
    check("rst_v_total", W'(v_total), W'(750));
    check("rst_timing", W'(act_tim), W'(tim_pkt(2'd0)));
    check("rst_mode_cur", W'(mode_cur), W'(0));
    check("rst_ready", W'(mode_ready), W'(1));
    check("rst_drv_rst_n", W'(drv_rst_n), W'(0));
    check("rst_flags", W'({mode_done, blank, vs_timeout}), W'(0));
    @(posedge pixel_clk);
    #1 sys_rst_n = 1'b1;
    @(negedge pixel_clk);
    check("drv_rst_before_edge", W'(drv_rst_n), W'(0));
    @(negedge pixel_clk);
    check("drv_rst_after_edge", W'(drv_rst_n), W'(1));

    // Same-mode request completes immediately
    issue_req(2'd0);
    @(negedge pixel_clk);
    check("same_done_n1", W'({mode_done, mode_ready, blank}), W'(3'b100));
    @(negedge pixel_clk);
    check("same_ready_n2", W'({mode_done, mode_ready, blank, drv_rst_n}), W'(4'b0101));

    // 0 -> 1 full sequence
    issue_req(2'd1);
    check_blank_rise();
    wait_done();

    // Request during blanking is dropped
    issue_req(2'd2);
    wait_level("wait_blank", 1'b1, 1'b1);
    check("busy_not_ready", W'(mode_ready), W'(0));
    issue_ignored(2'd3);
    wait_done();
    check("ignored_mode_cur", W'(mode_cur), W'(2));

    // Dead vsync: sequence completes on timeouts, flag sticks until next accept
    vs_hold_high = 1'b1;
    issue_req(2'd3);
    wait_done();
    check("timeout_flag", W'(vs_timeout), W'(1));
    repeat (50) @(negedge pixel_clk);
    check("timeout_sticky", W'(vs_timeout), W'(1));
    vs_hold_high = 1'b0;
    issue_req(2'd3);
    @(negedge pixel_clk);
    check("timeout_cleared", W'(vs_timeout), W'(0));
    wait_done();

    // Reset while the generator is held in reset
    issue_req(2'd1);
    wait_level("wait_hold", 1'b0, 1'b0);
    repeat (4) @(negedge pixel_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("midrst_state", W'({mode_cur, blank, drv_rst_n, mode_ready, mode_done}), W'({2'd0, 4'b0010}));
    check("midrst_timing", W'(act_tim), W'(tim_pkt(2'd0)));
    exp_q.delete();
    model_cur = 2'd0;
    last_tgt  = 2'd0;
    repeat (3) @(negedge pixel_clk);
    @(posedge pixel_clk);
    #1 sys_rst_n = 1'b1;
    repeat (2) @(negedge pixel_clk);
    check("midrst_release", W'({drv_rst_n, mode_ready}), W'(2'b11));

    // Randomized requests, some with a dropped request while busy
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 250)) @(negedge pixel_clk);
      m = 2'($urandom_range(0, 3));
      issue_req(m);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 300)) @(negedge pixel_clk);
        if (!mode_ready) issue_ignored(2'($urandom_range(0, 3)));
      end
      wait_done();
    end

    repeat (20) @(negedge pixel_clk);
    check("queue_empty", W'(exp_q.size()), W'(0));
    check("final_mode_cur", W'(mode_cur), W'(model_cur));
    $display("[TB] final fsm_state=%0d", fsm_state);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
